// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefW           = 16;
  localparam int unsigned DefAw          = 16;
  localparam int unsigned DefStarveLimit = 4;
  localparam int unsigned DefTimeout     = 64;

  // Raw 3-bit state codes
  localparam logic [2:0] StateIdle    = 3'd0;
  localparam logic [2:0] StateBusyIf  = 3'd1;
  localparam logic [2:0] StateBusyMem = 3'd2;
  localparam logic [2:0] StateRespIf  = 3'd3;
  localparam logic [2:0] StateRespMem = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = StateIdle,
    StBusyIf  = StateBusyIf,
    StBusyMem = StateBusyMem,
    StRespIf  = StateRespIf,
    StRespMem = StateRespMem
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } arb_gnt_e;

  function automatic logic is_busy(input arb_state_e s);
    return (s == StBusyIf) || (s == StBusyMem);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline/RAM side (master) and the arbiter (slave).
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned AW = DefAw
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [W-1:0]  if_rdata;
  logic          if_ack;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_ack;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;
  logic          ram_ready;
  logic          stall_fetch;
  logic          stall_pipe;

  modport master (
    output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata, ram_ready,
    input  if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_we, ram_addr, ram_wdata,
    input  stall_fetch, stall_pipe
  );

  modport slave (
    input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata, ram_ready,
    output if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_we, ram_addr, ram_wdata,
    output stall_fetch, stall_pipe
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive arbitrations lost by fetch; saturates at STARVE_LIMIT.
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_limit_hit
);

  logic [3:0] r_cnt;

  // Clear has priority over increment; hold at the limit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt != 4'(STARVE_LIMIT))) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_limit_hit = (r_cnt == 4'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port instruction/data RAM between fetch and the memory
// stage, memory stage first, with a starvation guard for fetch.
// Optional watchdog abort of stuck accesses: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned W            = DefW,
  parameter int unsigned AW           = DefAw,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit,
  parameter int unsigned TIMEOUT      = DefTimeout
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              arb_err
`endif
);

  arb_state_e    r_state;
  arb_state_e    w_state_d;
  arb_gnt_e      w_gnt;
  logic [AW-1:0] r_addr;
  logic [W-1:0]  r_wdata;
  logic          r_we;
  logic [W-1:0]  r_if_rdata;
  logic [W-1:0]  r_mem_rdata;
  logic          w_mem_req;
  logic          w_idle;
  logic          w_starve_hit;
  logic          w_starve_inc;
  logic          w_starve_clr;
  logic          w_abort;
  logic          w_done;
  logic [W-1:0]  w_rdata_in;

  assign w_mem_req = bus.mem_rd_req | bus.mem_wr_req;
  assign w_idle    = (r_state == StIdle);

  // Memory stage wins unless fetch has lost STARVE_LIMIT times in a row
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_mem_req && !(w_starve_hit && bus.if_req)) begin
      w_gnt = GNT_MEM;
    end else if (bus.if_req) begin
      w_gnt = GNT_IF;
    end
  end

  assign w_starve_inc = w_idle & bus.if_req & (w_gnt == GNT_MEM);
  assign w_starve_clr = ~bus.if_req | (w_idle & (w_gnt == GNT_IF));

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_starve_inc),
    .i_clr       (w_starve_clr),
    .o_limit_hit (w_starve_hit)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  logic [WdogW-1:0] r_wdog;
  logic             r_arb_err;

  assign w_abort = is_busy(r_state) & ~bus.ram_ready & (r_wdog == WdogW'(TIMEOUT - 1));

  // Watchdog counts cycles spent in BUSY; error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog    <= '0;
      r_arb_err <= 1'b0;
    end else begin
      if (is_busy(r_state)) begin
        r_wdog <= r_wdog + 1'b1;
      end else begin
        r_wdog <= '0;
      end
      if (w_abort) begin
        r_arb_err <= 1'b1;
      end
    end
  end

  assign arb_err = r_arb_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_abort          = 1'b0;
`endif

  assign w_done     = is_busy(r_state) & (bus.ram_ready | w_abort);
  // An aborted read returns all ones
  assign w_rdata_in = bus.ram_ready ? bus.ram_rdata : {W{1'b1}};

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_gnt == GNT_MEM) begin
          w_state_d = StBusyMem;
        end else if (w_gnt == GNT_IF) begin
          w_state_d = StBusyIf;
        end
      end
      StBusyIf:  if (w_done) w_state_d = StRespIf;
      StBusyMem: if (w_done) w_state_d = StRespMem;
      StRespIf:  w_state_d = StIdle;
      StRespMem: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // State register, grant-time latches and read-data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_idle && (w_gnt == GNT_MEM)) begin
        r_addr  <= bus.mem_addr;
        r_wdata <= bus.mem_wdata;
        r_we    <= bus.mem_wr_req;  // read+write together acts as a write
      end else if (w_idle && (w_gnt == GNT_IF)) begin
        r_addr <= bus.if_addr;
        r_we   <= 1'b0;
      end
      if ((r_state == StBusyIf) && w_done) begin
        r_if_rdata <= w_rdata_in;
      end
      if ((r_state == StBusyMem) && w_done && !r_we) begin
        r_mem_rdata <= w_rdata_in;
      end
    end
  end

  assign bus.ram_en      = is_busy(r_state);
  assign bus.ram_we      = (r_state == StBusyMem) & r_we;
  assign bus.ram_addr    = r_addr;
  assign bus.ram_wdata   = r_wdata;
  assign bus.if_ack      = (r_state == StRespIf);
  assign bus.mem_ack     = (r_state == StRespMem);
  assign bus.if_rdata    = r_if_rdata;
  assign bus.mem_rdata   = r_mem_rdata;
  assign bus.stall_pipe  = w_mem_req & ~bus.mem_ack;
  assign bus.stall_fetch = (bus.if_req & ~bus.if_ack) | bus.stall_pipe;

endmodule
